// File: rtl/holy_axi_lite_regbank.sv
// ----------------------------------------------------------------------------
// holy_axi_lite_regbank
//   Parametrised AXI-Lite slave register bank for the core peripheral bus.
//   One outstanding transaction at a time; writes take priority over reads
//   when both address channels are valid in IDLE.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*         AXI-Lite write address / data / response
//   s_axi_ar*/r*            AXI-Lite read address / data
//   hw_we[i]                load hw_wdata slice i into register i this cycle
//   hw_wdata                NUM_REGS x DATA_WIDTH hardware write data
//   reg_q                   NUM_REGS x DATA_WIDTH current register contents
// ----------------------------------------------------------------------------
module holy_axi_lite_regbank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    input  logic [NUM_REGS-1:0]            hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        SLAVE_IDLE,
        LITE_RECEIVING_WRITE_DATA,
        LITE_SENDING_WRITE_RES,
        LITE_SENDING_READ_DATA
    } state_t;

    state_t                               r_state;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  r_regs;
    logic [IDX_W-1:0]                     r_idx;    // write target latched at AW
    logic                                 r_wr_ok;  // write target in range and writable

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  w_hw;
    logic [ADDR_WIDTH-1:0]                w_aw_word, w_ar_word;
    logic [IDX_W-1:0]                     w_aw_idx, w_ar_idx;
    logic                                 w_aw_in, w_ar_in;
    logic                                 w_bus_we;

    assign w_hw  = hw_wdata;
    assign reg_q = r_regs;

    // Word index from byte address; sub-word offset bits are dropped.
    // Addresses below BASE_ADDR wrap to huge offsets, but are rejected
    // explicitly anyway so the check does not depend on that wrap.
    assign w_aw_word = (s_axi_awaddr - BASE_ADDR) >> LSB;
    assign w_ar_word = (s_axi_araddr - BASE_ADDR) >> LSB;
    assign w_aw_in   = (s_axi_awaddr >= BASE_ADDR) && (w_aw_word < ADDR_WIDTH'(NUM_REGS));
    assign w_ar_in   = (s_axi_araddr >= BASE_ADDR) && (w_ar_word < ADDR_WIDTH'(NUM_REGS));
    assign w_aw_idx  = w_aw_word[IDX_W-1:0];
    assign w_ar_idx  = w_ar_word[IDX_W-1:0];

    // Ready signals are pure state decodes; arready is also gated by awvalid
    // so a simultaneous AW/AR always resolves to the write.
    assign s_axi_awready = (r_state == SLAVE_IDLE);
    assign s_axi_arready = (r_state == SLAVE_IDLE) && !s_axi_awvalid;
    assign s_axi_wready  = (r_state == LITE_RECEIVING_WRITE_DATA);

    assign w_bus_we = (r_state == LITE_RECEIVING_WRITE_DATA) && s_axi_wvalid && r_wr_ok;

    // Register storage: strobed bus bytes override the hardware port byte-wise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (w_bus_we && (r_idx == IDX_W'(i)) && s_axi_wstrb[b])
                        r_regs[i][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                    else if (hw_we[i])
                        r_regs[i][b*8 +: 8] <= w_hw[i][b*8 +: 8];
                end
            end
        end
    end

    // Protocol FSM with registered response channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SLAVE_IDLE;
            r_idx        <= '0;
            r_wr_ok      <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
        end else begin
            case (r_state)
                SLAVE_IDLE: begin
                    if (s_axi_awvalid) begin
                        r_idx   <= w_aw_idx;
                        r_wr_ok <= w_aw_in && !RO_MASK[w_aw_idx];
                        r_state <= LITE_RECEIVING_WRITE_DATA;
                    end else if (s_axi_arvalid) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= w_ar_in ? r_regs[w_ar_idx] : '0;
                        s_axi_rresp  <= w_ar_in ? RESP_OKAY : RESP_SLVERR;
                        r_state      <= LITE_SENDING_READ_DATA;
                    end
                end
                LITE_RECEIVING_WRITE_DATA: begin
                    if (s_axi_wvalid) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= r_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state      <= LITE_SENDING_WRITE_RES;
                    end
                end
                LITE_SENDING_WRITE_RES: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        s_axi_bresp  <= RESP_OKAY;
                        r_state      <= SLAVE_IDLE;
                    end
                end
                LITE_SENDING_READ_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        s_axi_rresp  <= RESP_OKAY;
                        s_axi_rdata  <= '0;
                        r_state      <= SLAVE_IDLE;
                    end
                end
                default: r_state <= SLAVE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_holy_axi_lite_regbank.sv
// ----------------------------------------------------------------------------
// tb_holy_axi_lite_regbank
//   Directed bench for holy_axi_lite_regbank (32-bit data, 8 registers,
//   register 0 read-only). Inputs are driven and outputs sampled just after
//   the falling edge; handshakes happen on the rising edge.
// ----------------------------------------------------------------------------
module tb_holy_axi_lite_regbank;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 8;

    logic              clk, rst_n;
    logic [AW-1:0]     awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [DW-1:0]     wdata, rdata;
    logic [DW/8-1:0]   wstrb;
    logic [1:0]        bresp, rresp;
    logic [NR-1:0]     hw_we;
    logic [NR*DW-1:0]  hw_wdata, reg_q;

    int n_cmp = 0;
    int n_err = 0;

    holy_axi_lite_regbank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
        .BASE_ADDR(32'h0), .RO_MASK(8'h01)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready), .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .hw_we(hw_we), .hw_wdata(hw_wdata), .reg_q(reg_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All phase tasks start and end just after a falling edge.
    task automatic aw_phase(input logic [AW-1:0] a);
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        #1;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        if (!awready) chk("aw_timeout", {63'd0, awready}, 64'd1);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        wdata = d; wstrb = s; wvalid = 1'b1;
        #1;
        chk("wready_lat", {63'd0, wready}, 64'd1);
        @(posedge clk); @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic b_phase(output logic [1:0] resp);
        #1;
        chk("bvalid_lat", {63'd0, bvalid}, 64'd1);
        resp = bresp; bready = 1'b1;
        @(posedge clk); @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic ar_phase(input logic [AW-1:0] a);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        if (!arready) chk("ar_timeout", {63'd0, arready}, 64'd1);
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic r_phase(output logic [DW-1:0] d, output logic [1:0] resp);
        #1;
        chk("rvalid_lat", {63'd0, rvalid}, 64'd1);
        d = rdata; resp = rresp; rready = 1'b1;
        @(posedge clk); @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] s, output logic [1:0] resp);
        aw_phase(a);
        w_phase(d, s);
        b_phase(resp);
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic [1:0] resp);
        ar_phase(a);
        r_phase(d, resp);
    endtask

    logic [1:0]    resp;
    logic [DW-1:0] data;

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        hw_we = '0; hw_wdata = '0;

        // Reset state
        #1;
        chk("rst_awready", {63'd0, awready}, 64'd1);
        chk("rst_arready", {63'd0, arready}, 64'd1);
        chk("rst_wready",  {63'd0, wready},  64'd0);
        chk("rst_bvalid",  {63'd0, bvalid},  64'd0);
        chk("rst_rvalid",  {63'd0, rvalid},  64'd0);
        chk("rst_rdata",   {32'd0, rdata},   64'd0);
        chk("rst_reg_q0",  {32'd0, reg_q[0 +: 32]}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read register 1
        bus_write(32'h4, 32'hDEADBEEF, 4'hF, resp);
        chk("wr1_bresp", {62'd0, resp}, 64'd0);
        chk("wr1_reg1", {32'd0, reg_q[1*32 +: 32]}, 64'hDEADBEEF);
        bus_read(32'h4, data, resp);
        chk("rd1_data", {32'd0, data}, 64'hDEADBEEF);
        chk("rd1_rresp", {62'd0, resp}, 64'd0);

        // Byte strobes: bytes 0 and 2 only
        bus_write(32'h4, 32'h11223344, 4'b0101, resp);
        chk("strb_bresp", {62'd0, resp}, 64'd0);
        chk("strb_reg1", {32'd0, reg_q[1*32 +: 32]}, 64'hDE22BE44);

        // Hardware port loads a read-only register; bus write to it errors
        hw_we = 8'h01; hw_wdata[0 +: 32] = 32'h00000055;
        @(negedge clk);
        hw_we = '0;
        chk("hw_reg0", {32'd0, reg_q[0 +: 32]}, 64'h55);
        bus_write(32'h0, 32'h12345678, 4'hF, resp);
        chk("ro_bresp", {62'd0, resp}, 64'd2);
        chk("ro_reg0", {32'd0, reg_q[0 +: 32]}, 64'h55);

        // Out-of-range read, and sub-word address bits ignored
        bus_read(32'h20, data, resp);
        chk("oor_rdata", {32'd0, data}, 64'd0);
        chk("oor_rresp", {62'd0, resp}, 64'd2);
        bus_read(32'h7, data, resp);
        chk("lowbits_rdata", {32'd0, data}, 64'hDE22BE44);
        chk("lowbits_rresp", {62'd0, resp}, 64'd0);

        // Collision: AW and AR together -> write first, read after B
        awaddr = 32'h8; awvalid = 1'b1; araddr = 32'h4; arvalid = 1'b1;
        #1;
        chk("col_awready", {63'd0, awready}, 64'd1);
        chk("col_arready", {63'd0, arready}, 64'd0);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
        #1;
        chk("col_arready_w", {63'd0, arready}, 64'd0);
        w_phase(32'h0BADF00D, 4'hF);
        b_phase(resp);
        chk("col_bresp", {62'd0, resp}, 64'd0);
        chk("col_reg2", {32'd0, reg_q[2*32 +: 32]}, 64'h0BADF00D);
        #1;
        chk("col_arready_idle", {63'd0, arready}, 64'd1);
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        r_phase(data, resp);
        chk("col_rdata", {32'd0, data}, 64'hDE22BE44);

        // Write response backpressure: B held, new AW not accepted
        aw_phase(32'hC);
        w_phase(32'hCAFE0001, 4'hF);
        awaddr = 32'h10; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_bvalid",  {63'd0, bvalid},  64'd1);
            chk("bp_bresp",   {62'd0, bresp},   64'd0);
            chk("bp_awready", {63'd0, awready}, 64'd0);
            @(negedge clk);
        end
        awvalid = 1'b0;
        b_phase(resp);
        chk("bp_reg3", {32'd0, reg_q[3*32 +: 32]}, 64'hCAFE0001);
        chk("bp_reg4", {32'd0, reg_q[4*32 +: 32]}, 64'h0);

        // Same-cycle hardware and bus write to register 2
        aw_phase(32'h8);
        hw_we = 8'h04; hw_wdata[2*32 +: 32] = 32'hAAAAAAAA;
        w_phase(32'h000000FF, 4'b0001);
        hw_we = '0;
        b_phase(resp);
        chk("hwcol_bresp", {62'd0, resp}, 64'd0);
        chk("hwcol_reg2", {32'd0, reg_q[2*32 +: 32]}, 64'hAAAAAAFF);

        // Reset mid-read aborts the transaction
        ar_phase(32'h4);
        #1;
        chk("mid_rvalid_pre", {63'd0, rvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid", {63'd0, rvalid}, 64'd0);
        chk("mid_reg1", {32'd0, reg_q[1*32 +: 32]}, 64'd0);
        chk("mid_reg2", {32'd0, reg_q[2*32 +: 32]}, 64'd0);
        chk("mid_awready", {63'd0, awready}, 64'd1);
        chk("mid_arready", {63'd0, arready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("post_rvalid", {63'd0, rvalid}, 64'd0);
        chk("post_bvalid", {63'd0, bvalid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
